execute_stage_mdu: RTL and testbench
====================================

# execute_stage_mdu

Parametrised successor to the single-cycle execute stage. It adds operand forwarding from the MEM and WB stages, a registered EX/MEM output, and an iterative multiply/divide unit (RV32M semantics) with a stall handshake to the front of the pipeline. It sits between the ID/EX register and the memory stage. Single-cycle ALU ops complete in one cycle; MUL/DIV ops hold the pipeline until their result is registered.

## Interface
- XLEN, 32, datapath width (≥8, even)
- REG_W, 5, register-address width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  instruction present at stage input
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB; others → result 0
- md_en  in  1  instruction is multiply/divide (alu_op ignored)
- md_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- alu_src  in  1  right operand = immediate_data
- data1, data2, immediate_data  in  XLEN  register-file operands, immediate
- rs1, rs2, rd_in  in  REG_W  source/destination register numbers
- fwd_mem_we, fwd_wb_we  in  1  MEM/WB stage writes a register
- fwd_mem_rd, fwd_wb_rd  in  REG_W  MEM/WB destination
- fwd_mem_data, fwd_wb_data  in  XLEN  MEM/WB result
- flush  in  1  kill the instruction in this stage
- stall_out  out  1  upstream must hold its inputs
- out_valid  out  1  EX/MEM register holds a valid instruction
- alu_data, memory_data  out  XLEN  result; forwarded rs2 value for stores
- zero_flag  out  1  alu_data == 0
- rd_out  out  REG_W  destination
- illegal_md  out  1  md_en instruction executed with MDU compiled out

## Operation
- Forwarding per operand, before the alu_src mux: MEM match (we && rd==rs && rs!=0) wins over WB match; otherwise use data1/data2. Register 0 is never forwarded.
- memory_data is the forwarded rs2 value, never the immediate.
- FSM states IDLE, BUSY, DONE.
- IDLE with in_valid && !md_en: ALU result, memory_data, rd, zero_flag registered; out_valid=1 next cycle; stall_out=0.
- IDLE with in_valid && md_en: latch forwarded operands, md_op, rd. stall_out=1 combinationally this cycle. Move to BUSY with counter=XLEN-1. The out_valid of this cycle's registered output is 0.
- Special cases go straight to DONE, skipping BUSY:
  - divide by zero: quotient all-ones, remainder = dividend
  - signed MIN / -1: quotient MIN, remainder 0
- BUSY: one radix-2 step per cycle on operand magnitudes; shift-add for multiply, restoring for divide. A 2·XLEN product is kept. stall_out=1. At counter 0 go to DONE.
- DONE: apply sign correction and select the low/high half or quotient/remainder. Register the result with out_valid=1 and return to IDLE.
  - stall_out=0 in DONE, so upstream advances in the same cycle.
  - A new instruction on in_valid is not accepted in DONE; upstream presents it again in the following IDLE cycle.
- Signs: MULH signed×signed; MULHSU signed×unsigned; DIV/REM quotient sign = sign1^sign2, remainder sign = dividend sign.
- flush (any state): state → IDLE, out_valid=0 next cycle, stall_out=0 in that cycle; any in-flight MDU op is discarded.
- Idle cycles (in_valid=0) register out_valid=0; data registers hold their values.

## Timing
- Reset (rst=1 at a clk edge): state IDLE, out_valid 0, alu_data 0, memory_data 0, zero_flag 1, rd_out 0, illegal_md 0. stall_out=0 while rst is high.
- ALU op latency: 1 cycle.
- MDU latency:
  - normal op: XLEN+2 cycles from acceptance to out_valid (accept, XLEN BUSY, DONE)
  - special case: 2 cycles
- stall_out is high for exactly latency-1 consecutive cycles per MDU op.
- rst or flush during BUSY/DONE aborts the op with no out_valid pulse. rst wins over flush.
- Forwarding paths are combinational within the accept cycle; operands are not re-sampled during BUSY.

## Configuration
- RV_MDU_EN defined: MDU, BUSY/DONE states and stall logic present as above.
- RV_MDU_EN undefined:
  - no MDU hardware; stall_out tied 0
  - an md_en instruction completes in 1 cycle with alu_data 0 and out_valid 1
  - illegal_md=1 registered alongside that result (0 otherwise)

## Test plan
- Reset, then ADD 5+7 with alu_src=0 → next cycle out_valid=1, alu_data=12, zero_flag=0; SUB 7-7 → alu_data=0, zero_flag=1.
- Forwarding: rs1=3, MEM rd=3 data 0x10, WB rd=3 data 0x20, data1=0x30, ADD with immediate 1 → 0x11. Repeat with rs1=0 → 0x31.
- MUL 0xFFFFFFFF×0xFFFFFFFF (XLEN=32): MULHU → 0xFFFFFFFE, MULH → 0x0, MUL → 0x1. stall_out high 33 cycles; out_valid at cycle 34.
- DIV −7/2 → −3, REM → −1. DIVU 7/0 → 0xFFFFFFFF in 2 cycles. DIV 0x80000000/−1 → 0x80000000, REM → 0.
- flush asserted in BUSY cycle 10 → no out_valid pulse, stall_out low that cycle; following ADD completes in 1 cycle.
- Without RV_MDU_EN: MUL 3×4 → 1 cycle, alu_data 0, illegal_md 1, stall_out never high.

Source files
------------

// File: rtl/execute_stage_mdu_if.sv
// ============================================================================
// execute_stage_mdu_if : stage bundle between ID/EX, forwarding and EX/MEM
// Revision: 1.0
// ============================================================================
`default_nettype none

interface execute_stage_mdu_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic [3:0]       alu_op;
  logic             md_en;
  logic [2:0]       md_op;
  logic             alu_src;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [XLEN-1:0]  immediate_data;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd_in;
  logic             fwd_mem_we;
  logic             fwd_wb_we;
  logic [REG_W-1:0] fwd_mem_rd;
  logic [REG_W-1:0] fwd_wb_rd;
  logic [XLEN-1:0]  fwd_mem_data;
  logic [XLEN-1:0]  fwd_wb_data;
  logic             flush;
  logic             stall_out;
  logic             out_valid;
  logic [XLEN-1:0]  alu_data;
  logic [XLEN-1:0]  memory_data;
  logic             zero_flag;
  logic [REG_W-1:0] rd_out;
  logic             illegal_md;

  modport master (
    output in_valid, alu_op, md_en, md_op, alu_src, data1, data2, immediate_data,
           rs1, rs2, rd_in, fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd,
           fwd_mem_data, fwd_wb_data, flush,
    input  stall_out, out_valid, alu_data, memory_data, zero_flag, rd_out, illegal_md
  );

  modport slave (
    input  in_valid, alu_op, md_en, md_op, alu_src, data1, data2, immediate_data,
           rs1, rs2, rd_in, fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd,
           fwd_mem_data, fwd_wb_data, flush,
    output stall_out, out_valid, alu_data, memory_data, zero_flag, rd_out, illegal_md
  );
endinterface

`default_nettype wire

// File: rtl/execute_stage_mdu.sv
// ============================================================================
// execute_stage_mdu : forwarding execute stage, registered EX/MEM, iterative
// RV32M multiply/divide unit enabled by macro RV_MDU_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module execute_stage_mdu #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  execute_stage_mdu_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]  w_op1, w_op2, w_opb, w_alu;
  logic             w_stall;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  alu_data_q, alu_data_d;
  logic [XLEN-1:0]  memory_data_q, memory_data_d;
  logic             zero_q, zero_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             illegal_q, illegal_d;

  // MEM result is younger than WB, so it takes priority; x0 is hard-wired zero
  always_comb begin
    if (bus.fwd_mem_we && bus.fwd_mem_rd == bus.rs1 && bus.rs1 != '0)
      w_op1 = bus.fwd_mem_data;
    else if (bus.fwd_wb_we && bus.fwd_wb_rd == bus.rs1 && bus.rs1 != '0)
      w_op1 = bus.fwd_wb_data;
    else
      w_op1 = bus.data1;
    if (bus.fwd_mem_we && bus.fwd_mem_rd == bus.rs2 && bus.rs2 != '0)
      w_op2 = bus.fwd_mem_data;
    else if (bus.fwd_wb_we && bus.fwd_wb_rd == bus.rs2 && bus.rs2 != '0)
      w_op2 = bus.fwd_wb_data;
    else
      w_op2 = bus.data2;
    w_opb = bus.alu_src ? bus.immediate_data : w_op2;
  end

  always_comb begin
    w_alu = '0;
    case (bus.alu_op)
      4'd0:    w_alu = w_op1 + w_opb;
      4'd1:    w_alu = w_op1 - w_opb;
      4'd2:    w_alu = w_op1 & w_opb;
      4'd3:    w_alu = w_op1 | w_opb;
      4'd4:    w_alu = w_op1 ^ w_opb;
      4'd5:    w_alu = w_op1 << w_opb[SHW-1:0];
      4'd6:    w_alu = w_op1 >> w_opb[SHW-1:0];
      4'd7:    w_alu = $unsigned($signed(w_op1) >>> w_opb[SHW-1:0]);
      4'd8:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_opb))};
      4'd9:    w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_opb)};
      4'd10:   w_alu = w_opb;
      default: w_alu = '0;
    endcase
  end

`ifdef RV_MDU_EN
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   st_q, st_d;
  logic [2:0]        mdop_q, mdop_d;
  logic [REG_W-1:0]  mdrd_q, mdrd_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic              w_is_mul, w_sgn_a, w_sgn_b, w_sa, w_sb;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic [XLEN:0]     w_mul_sum, w_div_try;
  logic [2*XLEN-1:0] w_mul_step, w_div_step, w_full;
  logic [XLEN-1:0]   w_quo, w_rem, w_md_res;

  always_comb begin
    w_is_mul = !bus.md_op[2];
    w_sgn_a  = w_is_mul ? (bus.md_op == 3'd1 || bus.md_op == 3'd2) : !bus.md_op[0];
    w_sgn_b  = w_is_mul ? (bus.md_op == 3'd1) : !bus.md_op[0];
    w_sa     = w_sgn_a && w_op1[XLEN-1];
    w_sb     = w_sgn_b && w_op2[XLEN-1];
    w_mag1   = w_sa ? -w_op1 : w_op1;
    w_mag2   = w_sb ? -w_op2 : w_op2;
  end

  // acc holds {partial product, multiplier} or {partial remainder, quotient}
  always_comb begin
    w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    w_mul_step = {w_mul_sum, acc_q[XLEN-1:1]};
    w_div_try  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
    w_div_step = w_div_try[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {w_div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    w_full     = negq_q ? -acc_q : acc_q;
    w_quo      = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    w_rem      = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!mdop_q[2])
      w_md_res = (mdop_q == 3'd0) ? w_full[XLEN-1:0] : w_full[2*XLEN-1:XLEN];
    else
      w_md_res = mdop_q[1] ? w_rem : w_quo;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    st_d          = st_q;
    mdop_d        = mdop_q;
    mdrd_d        = mdrd_q;
    negq_d        = negq_q;
    negr_d        = negr_q;
    out_valid_d   = 1'b0;
    alu_data_d    = alu_data_q;
    memory_data_d = memory_data_q;
    zero_d        = zero_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    w_stall       = 1'b0;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && !bus.md_en) begin
            out_valid_d   = 1'b1;
            alu_data_d    = w_alu;
            memory_data_d = w_op2;
            zero_d        = (w_alu == '0);
            rd_d          = bus.rd_in;
            illegal_d     = 1'b0;
          end else if (bus.in_valid) begin
            w_stall = 1'b1;
            mdop_d  = bus.md_op;
            mdrd_d  = bus.rd_in;
            st_d    = w_op2;
            cnt_d   = SHW'(XLEN-1);
            state_d = S_BUSY;
            if (w_is_mul) begin
              acc_d   = {{XLEN{1'b0}}, w_mag2};
              mcand_d = w_mag1;
              negq_d  = w_sa ^ w_sb;
              negr_d  = 1'b0;
            end else if (w_op2 == '0) begin
              acc_d   = {w_op1, {XLEN{1'b1}}};
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = S_DONE;
            end else if (w_sgn_a && w_op1 == C_MIN && w_op2 == {XLEN{1'b1}}) begin
              acc_d   = {{XLEN{1'b0}}, C_MIN};
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, w_mag1};
              mcand_d = w_mag2;
              negq_d  = w_sa ^ w_sb;
              negr_d  = w_sa;
            end
          end
        end
        S_BUSY: begin
          w_stall = 1'b1;
          acc_d   = mdop_q[2] ? w_div_step : w_mul_step;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - SHW'(1);
        end
        S_DONE: begin
          out_valid_d   = 1'b1;
          alu_data_d    = w_md_res;
          memory_data_d = st_q;
          zero_d        = (w_md_res == '0);
          rd_d          = mdrd_q;
          illegal_d     = 1'b0;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      st_q    <= '0;
      mdop_q  <= '0;
      mdrd_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      st_q    <= st_d;
      mdop_q  <= mdop_d;
      mdrd_q  <= mdrd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end
`else
  // Without the MDU an md_en instruction retires at once with a zero result
  always_comb begin
    out_valid_d   = 1'b0;
    alu_data_d    = alu_data_q;
    memory_data_d = memory_data_q;
    zero_d        = zero_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    w_stall       = 1'b0;
    if (bus.in_valid && !bus.flush) begin
      out_valid_d   = 1'b1;
      alu_data_d    = bus.md_en ? '0 : w_alu;
      memory_data_d = w_op2;
      zero_d        = bus.md_en ? 1'b1 : (w_alu == '0);
      rd_d          = bus.rd_in;
      illegal_d     = bus.md_en;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      alu_data_q    <= '0;
      memory_data_q <= '0;
      zero_q        <= 1'b1;
      rd_q          <= '0;
      illegal_q     <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      alu_data_q    <= alu_data_d;
      memory_data_q <= memory_data_d;
      zero_q        <= zero_d;
      rd_q          <= rd_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.stall_out   = w_stall && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_data    = alu_data_q;
  assign bus.memory_data = memory_data_q;
  assign bus.zero_flag   = zero_q;
  assign bus.rd_out      = rd_q;
  assign bus.illegal_md  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage_mdu.sv
// ============================================================================
// tb_execute_stage_mdu : directed scoreboard bench for execute_stage_mdu
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage_mdu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_mdu_if #(.XLEN(32), .REG_W(5)) bus ();
  execute_stage_mdu #(.XLEN(32), .REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        zero;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_alu"},  bus.alu_data,           e.alu);
        chk({e.tag, "_mem"},  bus.memory_data,        e.mem);
        chk({e.tag, "_zero"}, {31'd0, bus.zero_flag}, {31'd0, e.zero});
        chk({e.tag, "_rd"},   {27'd0, bus.rd_out},    {27'd0, e.rd});
        chk({e.tag, "_ill"},  {31'd0, bus.illegal_md}, {31'd0, e.ill});
      end
    end
  end

  task automatic push(input string tag, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] rd, input logic ill);
    exp_t e;
    e.tag = tag; e.alu = alu; e.mem = mem; e.zero = (alu == 32'd0); e.rd = rd; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.alu_op = 0; bus.md_en = 0; bus.md_op = 0; bus.alu_src = 0;
    bus.data1 = 0; bus.data2 = 0; bus.immediate_data = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.rd_in = 0;
    bus.fwd_mem_we = 0; bus.fwd_wb_we = 0; bus.fwd_mem_rd = 0; bus.fwd_wb_rd = 0;
    bus.fwd_mem_data = 0; bus.fwd_wb_data = 0; bus.flush = 0;
  endtask

  // Single-cycle op; expected memory_data is given explicitly (forwarded rs2)
  task automatic issue_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic src,
                           input logic [4:0] rs1, input logic [4:0] rd,
                           input logic [31:0] exp_alu, input logic [31:0] exp_mem);
    bus.in_valid = 1; bus.md_en = 0; bus.alu_op = op; bus.data1 = a; bus.data2 = b;
    bus.immediate_data = imm; bus.alu_src = src; bus.rs1 = rs1; bus.rs2 = 5'd0; bus.rd_in = rd;
    push(tag, exp_alu, exp_mem, rd, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 0;
    chk({tag, "_lat"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  // MDU op held while stall_out is high; stall cycles and latency are checked
  task automatic issue_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_alu,
                          input logic exp_ill, input int exp_stall, input int exp_lat);
    int stalls = 0;
    int cyc = 0;
    bit done = 0;
    logic s;
    bus.in_valid = 1; bus.md_en = 1; bus.md_op = op; bus.data1 = a; bus.data2 = b;
    bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.rd_in = rd; bus.alu_src = 0;
    push(tag, exp_alu, b, rd, exp_ill);
    while (!done && cyc < 200) begin
      #1 s = bus.stall_out;
      if (s === 1'b1) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (s !== 1'b1) done = 1;
    end
    bus.in_valid = 0; bus.md_en = 0;
    chk({tag, "_stall"}, stalls, exp_stall);
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_ov"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov",    {31'd0, bus.out_valid},  32'd0);
    chk("rst_alu",   bus.alu_data,            32'd0);
    chk("rst_mem",   bus.memory_data,         32'd0);
    chk("rst_zero",  {31'd0, bus.zero_flag},  32'd1);
    chk("rst_rd",    {27'd0, bus.rd_out},     32'd0);
    chk("rst_ill",   {31'd0, bus.illegal_md}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_out},  32'd0);
    rst = 0;
    @(posedge clk); #1;

    issue_alu("add",  4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 5'd4, 32'd12, 32'd7);
    issue_alu("sub",  4'd1, 32'd7, 32'd7, 32'd0, 1'b0, 5'd1, 5'd5, 32'd0,  32'd7);
    issue_alu("slt",  4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1, 5'd6, 32'd1, 32'd1);
    issue_alu("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1, 5'd7, 32'd0, 32'd1);
    issue_alu("xor",  4'd4, 32'hF0F0_1234, 32'h0FF0_0034, 32'd0, 1'b0, 5'd1, 5'd8,
              32'hFF00_1200, 32'h0FF0_0034);
    issue_alu("bad",  4'd12, 32'd9, 32'd3, 32'd0, 1'b0, 5'd1, 5'd9, 32'd0, 32'd3);
    issue_alu("sra",  4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd1, 5'd10,
              32'hF800_0000, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ov",   {31'd0, bus.out_valid}, 32'd0);
    chk("idle_hold", bus.alu_data, 32'hF800_0000);

    bus.fwd_mem_we = 1; bus.fwd_mem_rd = 5'd3; bus.fwd_mem_data = 32'h10;
    bus.fwd_wb_we  = 1; bus.fwd_wb_rd  = 5'd3; bus.fwd_wb_data  = 32'h20;
    issue_alu("fwd_mem", 4'd0, 32'h30, 32'h55, 32'd1, 1'b1, 5'd3, 5'd11, 32'h11, 32'h55);
    issue_alu("fwd_x0",  4'd0, 32'h30, 32'h55, 32'd1, 1'b1, 5'd0, 5'd12, 32'h31, 32'h55);
    bus.fwd_mem_we = 0;
    issue_alu("fwd_wb",  4'd0, 32'h30, 32'h55, 32'd1, 1'b1, 5'd3, 5'd13, 32'h21, 32'h55);
    bus.fwd_wb_we = 0;

`ifdef RV_MDU_EN
    issue_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 1'b0, 33, 34);
    issue_md("mulh",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'h0, 1'b0, 33, 34);
    issue_md("mul",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h1, 1'b0, 33, 34);
    issue_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd17, 32'hFFFF_FFFF, 1'b0, 33, 34);
    issue_md("div",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd18, 32'hFFFF_FFFD, 1'b0, 33, 34);
    issue_md("rem",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd19, 32'hFFFF_FFFF, 1'b0, 33, 34);
    issue_md("divu0", 3'd5, 32'd7, 32'd0, 5'd20, 32'hFFFF_FFFF, 1'b0, 1, 2);
    issue_md("remu0", 3'd7, 32'd7, 32'd0, 5'd21, 32'd7, 1'b0, 1, 2);
    issue_md("divmin", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1'b0, 1, 2);
    issue_md("remmin", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0, 1'b0, 1, 2);
    issue_md("divu",  3'd5, 32'd100, 32'd7, 5'd24, 32'd14, 1'b0, 33, 34);

    begin
      bit seen = 0;
      bus.in_valid = 1; bus.md_en = 1; bus.md_op = 3'd0; bus.data1 = 32'd3; bus.data2 = 32'd4;
      bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.rd_in = 5'd25;
      @(posedge clk); #1;
      repeat (9) begin @(posedge clk); #1; end
      bus.flush = 1;
      #1;
      chk("flush_stall", {31'd0, bus.stall_out}, 32'd0);
      @(posedge clk); #1;
      bus.flush = 0; bus.in_valid = 0; bus.md_en = 0;
      repeat (40) begin
        if (bus.out_valid === 1'b1) seen = 1;
        @(posedge clk); #1;
      end
      chk("flush_no_ov", {31'd0, seen}, 32'd0);
    end
    issue_alu("add_after_flush", 4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 5'd1, 5'd26, 32'd42, 32'd22);
`else
    issue_md("mul_nomdu", 3'd0, 32'd3, 32'd4, 5'd14, 32'd0, 1'b1, 0, 1);
    issue_alu("add_after_ill", 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 5'd15, 32'd3, 32'd2);
    @(posedge clk); #1;
    chk("ill_cleared", {31'd0, bus.illegal_md}, 32'd0);
    bus.flush = 1; bus.in_valid = 1; bus.alu_op = 4'd0; bus.data1 = 32'd1;
    @(posedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    chk("flush_ov", {31'd0, bus.out_valid}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
